link_rx_responder: RTL and testbench



---
 rtl/link_pkg.sv | 14 +
 rtl/link_rx_fifo.sv | 52 +++++
 rtl/link_rx_responder.sv | 148 ++++++++++++++
 tb/tb_link_rx_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the 4-phase req/ack byte link (master and responder ends).
package link_pkg;

    localparam int unsigned LINK_DATA_W    = 8;
    localparam int unsigned LINK_BURST_LEN = 4;
    localparam int unsigned LINK_ACK_HOLD  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWaitLow
    } link_state_e;

endpackage

// File: rtl/link_rx_fifo.sv
// First-word-fall-through receive buffer for link_rx_responder.
module link_rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/link_rx_responder.sv
// Responder end of the req/ack byte link: acks each byte, buffers it, tracks bursts.
// Optional LINK_RX_CSUM_EN adds a running per-burst XOR checksum output (csum).
module link_rx_responder
    import link_pkg::*;
#(
    parameter int unsigned DATA_W     = LINK_DATA_W,
    parameter int unsigned BURST_LEN  = LINK_BURST_LEN,
    parameter int unsigned ACK_HOLD   = LINK_ACK_HOLD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req,
    input  logic [DATA_W-1:0]                data,
    output logic                             ack,
    input  logic                             rd_en,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             empty,
    output logic                             full,
    output logic [$clog2(BURST_LEN+1)-1:0]   byte_cnt,
    output logic [DATA_W-1:0]                last_byte,
    output logic                             done
`ifdef LINK_RX_CSUM_EN
    ,
    output logic [DATA_W-1:0]                csum
`endif
);

    localparam int unsigned CNT_W  = $clog2(BURST_LEN+1);
    localparam int unsigned HOLD_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;

    link_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ack_q, ack_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              done_q, done_d;
    logic              accept;
`ifdef LINK_RX_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    // full is registered occupancy, so a same-cycle pop cannot unblock this edge.
    assign accept = (state_q == StIdle) && req && !full;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = done_q;
`ifdef LINK_RX_CSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    ack_d   = 1'b1;
                    hold_d  = HOLD_W'(ACK_HOLD - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (!req) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end else begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = StIdle;
            end
        endcase

        // A new burst implicitly clears a sticky done from the previous one.
        if (accept) begin
            last_d = data;
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                done_d = 1'b0;
            end
`ifdef LINK_RX_CSUM_EN
            csum_d = (cnt_q == '0) ? data : (csum_q ^ data);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
`ifdef LINK_RX_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef LINK_RX_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    link_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full)
    );

    assign ack       = ack_q;
    assign byte_cnt  = cnt_q;
    assign last_byte = last_q;
    assign done      = done_q;
`ifdef LINK_RX_CSUM_EN
    assign csum      = csum_q;
`endif

endmodule

// File: tb/tb_link_rx_responder.sv
// Self-checking bench for link_rx_responder against a transaction-level reference model.
module tb_link_rx_responder;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BURST_LEN  = 4;
    localparam int unsigned ACK_HOLD   = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = $clog2(BURST_LEN+1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              rd_en = 1'b0;
    logic              ack;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] last_byte;
    logic              done;
`ifdef LINK_RX_CSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    link_rx_responder #(
        .DATA_W     (DATA_W),
        .BURST_LEN  (BURST_LEN),
        .ACK_HOLD   (ACK_HOLD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .byte_cnt  (byte_cnt),
        .last_byte (last_byte),
        .done      (done)
`ifdef LINK_RX_CSUM_EN
        ,
        .csum      (csum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: buffered bytes, burst position, sticky done, last byte, checksum.
    logic [DATA_W-1:0] mq[$];
    int                m_cnt  = 0;
    bit                m_done = 1'b0;
    logic [DATA_W-1:0] m_last = '0;
    logic [DATA_W-1:0] m_csum = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt  = 0;
        m_done = 1'b0;
        m_last = '0;
        m_csum = '0;
    endtask

    task automatic model_accept(input logic [DATA_W-1:0] d);
        m_csum = (m_cnt == 0) ? d : (m_csum ^ d);
        m_cnt++;
        m_done = (m_cnt == BURST_LEN);
        if (m_done) m_cnt = 0;
        m_last = d;
        mq.push_back(d);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == FIFO_DEPTH));
        chk({tag, ".byte_cnt"}, 32'(byte_cnt), 32'(m_cnt));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".last_byte"}, 32'(last_byte), 32'(m_last));
        if (mq.size() > 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
`ifdef LINK_RX_CSUM_EN
        chk({tag, ".csum"}, 32'(csum), 32'(m_csum));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("reset.ack", 32'(ack), 32'd0);
        check_state("reset");
    endtask

    // Called on the negedge where ack was first seen high; req is dropped after 'extra' more cycles.
    task automatic finish_hs(input int extra);
        int high;
        bit fell;
        int exp_w;
        high = 0;
        fell = 1'b0;
        for (int i = 0; i <= extra; i++) begin
            if (i > 0) @(negedge clk);
            if (ack === 1'b1) high++;
        end
        req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (ack === 1'b1) high++;
            else begin
                fell = 1'b1;
                break;
            end
        end
        exp_w = (extra + 1 > int'(ACK_HOLD)) ? extra + 1 : int'(ACK_HOLD);
        chk("ack_fell", 32'(fell), 32'd1);
        chk("ack_width", 32'(high), 32'(exp_w));
        check_state("post_hs");
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int extra);
        req = 1'b1;
        data = d;
        if (mq.size() == FIFO_DEPTH) begin
            repeat (3) begin
                @(negedge clk);
                chk("stall.ack", 32'(ack), 32'd0);
            end
            chk("stall.rd_data", 32'(rd_data), 32'(mq[0]));
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            void'(mq.pop_front());
            chk("stall.after_pop.ack", 32'(ack), 32'd0);
            check_state("stall.after_pop");
        end
        @(negedge clk);
        chk("ack_rise", 32'(ack), 32'd1);
        model_accept(d);
        check_state("capture");
        finish_hs(extra);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        check_state("pop");
    endtask

    task automatic reset_mid(input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
        send(d1, 0);
        req = 1'b1;
        data = d2;
        @(negedge clk);
        chk("rmid.ack_rise", 32'(ack), 32'd1);
        model_accept(d2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rmid.ack", 32'(ack), 32'd0);
        check_state("rmid");
        @(negedge clk);
        chk("rmid.reaccept", 32'(ack), 32'd1);
        model_accept(d2);
        check_state("rmid.byte1");
        finish_hs(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Burst A1..A4 with a consumer popping after every byte.
        send(8'hA1, 1); pop();
        send(8'hA2, 1); pop();
        send(8'hA3, 1); pop();
        send(8'hA4, 1); pop();

        // Long req hold: ack stretches, single write.
        send(8'($urandom), 5);
        pop();

        // Fill the buffer, then stall until one pop frees a slot.
        for (int i = 0; i < int'(FIFO_DEPTH) + 1; i++) send(8'($urandom), 0);
        while (mq.size() > 0) pop();

        reset_mid(8'h11, 8'h22);
        pop();

        // Two back-to-back bursts, then a pop on empty.
        for (int i = 0; i < 2 * int'(BURST_LEN); i++) begin
            send(8'($urandom), int'($urandom_range(0, 2)));
            pop();
        end
        pop();
        pop();

        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) pop();
        end
        while (mq.size() > 0) pop();
        pop();

`ifdef LINK_RX_CSUM_EN
        do_reset();
        send(8'h0F, 0); send(8'hF0, 0); send(8'h33, 0); send(8'h55, 0);
        chk("csum.burst1", 32'(csum), 32'h99);
        chk("csum.done1", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) send(8'h01, 0);
        chk("csum.burst2", 32'(csum), 32'h00);
        chk("csum.done2", 32'(done), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
